// File: rtl/ppi_pkg.sv
// Shared definitions for the i8255 bus master: FSM states, register addresses
// and control-word layout.
package ppi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } ppi_state_t;

  typedef logic [1:0] ppi_addr_t;

  localparam ppi_addr_t PPI_PORT_A = 2'd0;
  localparam ppi_addr_t PPI_PORT_B = 2'd1;
  localparam ppi_addr_t PPI_PORT_C = 2'd2;
  localparam ppi_addr_t PPI_CTRL   = 2'd3;

  // Bit 7 set selects mode definition; clear selects port C bit set/reset.
  localparam logic [7:0] PPI_MODE_SET = 8'h80;
  localparam int PPI_FLAG_BIT = 7;

  localparam int PPI_GA_MODE_LSB = 5;
  localparam int PPI_GA_MODE_MSB = 6;
  localparam int PPI_PA_DIR_BIT  = 4;
  localparam int PPI_PCU_DIR_BIT = 3;
  localparam int PPI_GB_MODE_BIT = 2;
  localparam int PPI_PB_DIR_BIT  = 1;
  localparam int PPI_PCL_DIR_BIT = 0;

  function automatic logic [7:0] ppi_mode_word(input logic [1:0] gaMode, input logic paIn,
                                               input logic pcuIn, input logic gbMode,
                                               input logic pbIn, input logic pclIn);
    logic [7:0] w;
    w = PPI_MODE_SET;
    w[PPI_GA_MODE_MSB:PPI_GA_MODE_LSB] = gaMode;
    w[PPI_PA_DIR_BIT]  = paIn;
    w[PPI_PCU_DIR_BIT] = pcuIn;
    w[PPI_GB_MODE_BIT] = gbMode;
    w[PPI_PB_DIR_BIT]  = pbIn;
    w[PPI_PCL_DIR_BIT] = pclIn;
    return w;
  endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// CPU request/done handshake plus split i8255 bus lines between the master
// and its surroundings.
interface ppi_bus_master_if;
  import ppi_pkg::*;

  logic       req;
  logic       wr;
  ppi_addr_t  addr_in;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       ncs;
  logic       nrd;
  logic       nwr;
  ppi_addr_t  addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  modport master (
    input  req, wr, addr_in, wdata, data_in,
    output ready, done, rdata, ncs, nrd, nwr, addr, data_out, data_oe
  );

  modport slave (
    output req, wr, addr_in, wdata, data_in,
    input  ready, done, rdata, ncs, nrd, nwr, addr, data_out, data_oe
  );

endinterface

// File: rtl/ppi_bus_master.sv
// Turns a single request/done handshake into an i8255 read or write cycle with
// programmable setup, strobe and hold widths. All bus outputs are registered.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input logic              clk,
  input logic              reset,
  ppi_bus_master_if.master bus
);

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);

  ppi_state_t state;
  logic [7:0] cnt;
  logic       isWrite;

  // Outputs are updated on the transition into each state, so the bus pins
  // always reflect the current state with no decode after the flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      isWrite      <= 1'b0;
      bus.ready    <= 1'b1;
      bus.done     <= 1'b0;
      bus.rdata    <= 8'h00;
      bus.ncs      <= 1'b1;
      bus.nrd      <= 1'b1;
      bus.nwr      <= 1'b1;
      bus.addr     <= PPI_CTRL;
      bus.data_out <= 8'h00;
      bus.data_oe  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            isWrite      <= bus.wr;
            bus.addr     <= bus.addr_in;
            bus.data_out <= bus.wdata;
            bus.data_oe  <= bus.wr;
            bus.ncs      <= 1'b0;
            bus.ready    <= 1'b0;
            cnt          <= SETUP_LOAD;
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == 8'd0) begin
            cnt   <= STROBE_LOAD;
            state <= ST_STROBE;
            if (isWrite) bus.nwr <= 1'b0;
            else         bus.nrd <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          // Read data is sampled on the edge that ends the strobe, while nrd is still low.
          if (cnt == 8'd0) begin
            if (!isWrite) bus.rdata <= bus.data_in;
            bus.nrd <= 1'b1;
            bus.nwr <= 1'b1;
            cnt     <= HOLD_LOAD;
            state   <= ST_HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd0) begin
            bus.ncs     <= 1'b1;
            bus.data_oe <= 1'b0;
            bus.ready   <= 1'b1;
            bus.done    <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Scoreboard bench for ppi_bus_master: default-timing and stretched-timing
// instances, a bus monitor per instance that checks each cycle at done.
module tb_ppi_bus_master;
  import ppi_pkg::*;

  localparam int S1 = 3;
  localparam int T1 = 5;
  localparam int H1 = 2;

  typedef struct {
    logic       isWr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         s, t, h;
    int         gap;
    int         acceptCyc;
  } exp_t;

  typedef struct {
    int         csLen, setupLen, strobeLen, holdLen;
    int         gapCnt, gapBefore, oeHi, bad, glitch;
    logic       sawWr, sawRd, prevNcs, oe0;
    logic [1:0] addr0;
    logic [7:0] d0;
  } mon_t;

  logic clk = 1'b0;
  logic reset0, reset1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] lastRead0 = 8'h00;
  logic [7:0] lastRead1 = 8'h00;
  mon_t mon0, mon1;

  ppi_bus_master_if bus0();
  ppi_bus_master_if bus1();

  ppi_bus_master dut0 (.clk(clk), .reset(reset0), .bus(bus0.master));
  ppi_bus_master #(.SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1))
    dut1 (.clk(clk), .reset(reset1), .bus(bus1.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] respOf(input logic [1:0] a);
    case (a)
      2'd0:    return 8'hD0;
      2'd1:    return 8'h5A;
      2'd2:    return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  // The peripheral only drives read data while nrd is low.
  assign bus0.data_in = (bus0.nrd === 1'b0) ? respOf(bus0.addr) : 8'h00;
  assign bus1.data_in = (bus1.nrd === 1'b0) ? respOf(bus1.addr) : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mon_t monInit();
    mon_t m;
    m.csLen = 0; m.setupLen = 0; m.strobeLen = 0; m.holdLen = 0;
    m.gapCnt = 0; m.gapBefore = 0; m.oeHi = 0; m.bad = 0; m.glitch = 0;
    m.sawWr = 1'b0; m.sawRd = 1'b0; m.prevNcs = 1'b1; m.oe0 = 1'b0;
    m.addr0 = 2'd0; m.d0 = 8'h00;
    return m;
  endfunction

  function automatic mon_t monStep(input mon_t mi, input logic ncs, input logic nrd,
                                   input logic nwr, input logic oe,
                                   input logic [1:0] a, input logic [7:0] d);
    mon_t m;
    m = mi;
    if (ncs !== 1'b0) begin
      if (nrd === 1'b0 || nwr === 1'b0 || oe === 1'b1) m.glitch++;
      if (m.gapCnt < 255) m.gapCnt++;
    end else begin
      if (m.prevNcs) begin
        m.csLen = 0; m.setupLen = 0; m.strobeLen = 0; m.holdLen = 0;
        m.oeHi = 0; m.bad = 0; m.sawWr = 1'b0; m.sawRd = 1'b0;
        m.gapBefore = m.gapCnt; m.gapCnt = 0;
        m.addr0 = a; m.d0 = d; m.oe0 = oe;
      end
      m.csLen++;
      if (nwr === 1'b0 || nrd === 1'b0) begin
        if (m.holdLen > 0) m.bad++;
        m.strobeLen++;
      end else if (m.strobeLen == 0) m.setupLen++;
      else m.holdLen++;
      if (nwr === 1'b0) m.sawWr = 1'b1;
      if (nrd === 1'b0) m.sawRd = 1'b1;
      if (nwr === 1'b0 && nrd === 1'b0) m.bad++;
      if (a !== m.addr0 || oe !== m.oe0 || (oe === 1'b1 && d !== m.d0)) m.bad++;
      if (oe === 1'b1) m.oeHi++;
    end
    m.prevNcs = (ncs !== 1'b0);
    return m;
  endfunction

  task automatic finishTxn(input int sel, input mon_t m, input logic prev,
                           input logic [7:0] rdataNow, input int cycNow);
    exp_t e;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpectedDone%0d: got done=1, expected done=0 (t=%0t)", sel, $time);
      return;
    end
    e = (sel == 0) ? q0.pop_front() : q1.pop_front();
    checkOutput("setupLen", m.setupLen, e.s);
    checkOutput("strobeLen", m.strobeLen, e.t);
    checkOutput("holdLen", m.holdLen, e.h);
    checkOutput("nwrSeen", {31'd0, m.sawWr}, {31'd0, e.isWr});
    checkOutput("nrdSeen", {31'd0, m.sawRd}, {31'd0, ~e.isWr});
    checkOutput("busAddr", {30'd0, m.addr0}, {30'd0, e.addr});
    if (e.isWr) checkOutput("busData", {24'd0, m.d0}, {24'd0, e.wdata});
    checkOutput("oeCycles", m.oeHi, e.isWr ? e.s + e.t + e.h : 0);
    checkOutput("busStable", m.bad, 0);
    checkOutput("doneAfterNcs", {31'd0, prev}, 32'd0);
    checkOutput("rdata", {24'd0, rdataNow}, {24'd0, e.rdata});
    checkOutput("latency", cycNow - e.acceptCyc, e.s + e.t + e.h + 1);
    if (e.gap >= 0) checkOutput("ncsGap", m.gapBefore, e.gap);
  endtask

  // Bus monitors: one per instance, sampling on the falling edge.
  initial begin
    logic prev;
    mon0 = monInit();
    forever begin
      @(negedge clk);
      prev = mon0.prevNcs;
      mon0 = monStep(mon0, bus0.ncs, bus0.nrd, bus0.nwr, bus0.data_oe, bus0.addr, bus0.data_out);
      if (bus0.done === 1'b1) finishTxn(0, mon0, prev, bus0.rdata, cyc);
    end
  end

  initial begin
    logic prev;
    mon1 = monInit();
    forever begin
      @(negedge clk);
      prev = mon1.prevNcs;
      mon1 = monStep(mon1, bus1.ncs, bus1.nrd, bus1.nwr, bus1.data_oe, bus1.addr, bus1.data_out);
      if (bus1.done === 1'b1) finishTxn(1, mon1, prev, bus1.rdata, cyc);
    end
  end

  // Waits for an idle master, presents one request and records its expectation.
  task automatic applyStimulus(input int sel, input logic isWr, input logic [1:0] a,
                               input logic [7:0] d, input logic keep, input int gap);
    int   waitCnt;
    exp_t e;
    waitCnt = 0;
    @(negedge clk);
    while (((sel == 0) ? bus0.ready : bus1.ready) !== 1'b1 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL readyTimeout%0d: got ready=0, expected ready=1 within 100 cycles", sel);
      return;
    end
    e.isWr = isWr; e.addr = a; e.wdata = d; e.gap = gap; e.acceptCyc = cyc;
    if (sel == 0) begin
      bus0.req = 1'b1; bus0.wr = isWr; bus0.addr_in = a; bus0.wdata = d;
      if (!isWr) lastRead0 = respOf(a);
      e.rdata = lastRead0; e.s = 1; e.t = 2; e.h = 1;
      q0.push_back(e);
    end else begin
      bus1.req = 1'b1; bus1.wr = isWr; bus1.addr_in = a; bus1.wdata = d;
      if (!isWr) lastRead1 = respOf(a);
      e.rdata = lastRead1; e.s = S1; e.t = T1; e.h = H1;
      q1.push_back(e);
    end
    @(negedge clk);
    if (!keep) begin
      if (sel == 0) bus0.req = 1'b0;
      else          bus1.req = 1'b0;
    end
  endtask

  task automatic checkIdle(input int sel, input logic [7:0] expRdata);
    logic [7:0] rd;
    rd = (sel == 0) ? bus0.rdata : bus1.rdata;
    checkOutput("rstReady", {31'd0, (sel == 0) ? bus0.ready : bus1.ready}, 32'd1);
    checkOutput("rstDone", {31'd0, (sel == 0) ? bus0.done : bus1.done}, 32'd0);
    checkOutput("rstNcs", {31'd0, (sel == 0) ? bus0.ncs : bus1.ncs}, 32'd1);
    checkOutput("rstNrd", {31'd0, (sel == 0) ? bus0.nrd : bus1.nrd}, 32'd1);
    checkOutput("rstNwr", {31'd0, (sel == 0) ? bus0.nwr : bus1.nwr}, 32'd1);
    checkOutput("rstOe", {31'd0, (sel == 0) ? bus0.data_oe : bus1.data_oe}, 32'd0);
    checkOutput("rstRdata", {24'd0, rd}, {24'd0, expRdata});
  endtask

  initial begin
    int waitCnt;
    reset0 = 1'b1; reset1 = 1'b1;
    bus0.req = 1'b0; bus0.wr = 1'b0; bus0.addr_in = 2'd0; bus0.wdata = 8'h00;
    bus1.req = 1'b0; bus1.wr = 1'b0; bus1.addr_in = 2'd0; bus1.wdata = 8'h00;
    repeat (3) @(negedge clk);
    checkIdle(0, 8'h00);
    checkIdle(1, 8'h00);
    checkOutput("rstAddr", {30'd0, bus0.addr}, {30'd0, PPI_CTRL});
    checkOutput("rstDataOut", {24'd0, bus0.data_out}, 32'd0);
    reset0 = 1'b0; reset1 = 1'b0;

    $display("[TB] write 0x90 to control, then read port A");
    applyStimulus(0, 1'b1, PPI_CTRL, 8'h90, 1'b0, -1);
    applyStimulus(0, 1'b0, PPI_PORT_A, 8'h00, 1'b0, -1);

    $display("[TB] three back-to-back requests with req held high");
    applyStimulus(0, 1'b1, PPI_CTRL, PPI_MODE_SET, 1'b1, -1);
    applyStimulus(0, 1'b1, PPI_PORT_A, 8'h35, 1'b1, 1);
    applyStimulus(0, 1'b0, PPI_PORT_C, 8'h00, 1'b0, 1);

    $display("[TB] reset during the second strobe cycle of a write");
    applyStimulus(0, 1'b1, PPI_PORT_B, 8'hAA, 1'b0, -1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("preResetNwr", {31'd0, bus0.nwr}, 32'd0);
    reset0 = 1'b1;
    void'(q0.pop_back());
    lastRead0 = 8'h00;
    @(negedge clk);
    reset0 = 1'b0;
    checkIdle(0, 8'h00);
    repeat (6) @(negedge clk);

    $display("[TB] request inputs disturbed while busy");
    applyStimulus(0, 1'b1, PPI_PORT_B, 8'h6E, 1'b1, -1);
    bus0.req = 1'b0; bus0.addr_in = PPI_PORT_C; bus0.wdata = 8'hFF; bus0.wr = 1'b0;
    @(negedge clk);
    bus0.req = 1'b1; bus0.addr_in = PPI_PORT_A;
    @(negedge clk);
    bus0.req = 1'b0;

    $display("[TB] stretched timing instance");
    applyStimulus(1, 1'b1, PPI_PORT_B, 8'hC3, 1'b0, -1);
    applyStimulus(1, 1'b0, PPI_PORT_B, 8'h00, 1'b0, -1);

    waitCnt = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    repeat (4) @(negedge clk);
    checkOutput("pending0", q0.size(), 0);
    checkOutput("pending1", q1.size(), 0);
    checkOutput("glitch0", mon0.glitch, 0);
    checkOutput("glitch1", mon1.glitch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
